// File: rtl/mimosa_dbg_uart.sv
// Snapshots the four mimosa debug state buses and streams them as a 6-byte UART 8N1 frame:
// header 0xA5, energy, stress, pleasure, nourishment, checksum.
module mimosa_dbg_uart #(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] dbg_energy,
  input  logic [6:0] dbg_stress,
  input  logic [6:0] dbg_pleasure,
  input  logic [6:0] dbg_nourishment,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  localparam logic [15:0] BaudMax  = 16'(CLK_DIV - 1);
  localparam logic [2:0]  LastByte = 3'd5;
  localparam logic [7:0]  Header   = 8'hA5;

  logic [1:0]  state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  byte_q, byte_d;
  logic [6:0]  energy_q, energy_d;
  logic [6:0]  stress_q, stress_d;
  logic [6:0]  pleasure_q, pleasure_d;
  logic [6:0]  nourish_q, nourish_d;
  logic        pending_q, pending_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic       bit_end;
  logic       frame_end;
  logic       accept;
  logic       chain;
  logic       take_snap;
  logic [7:0] checksum;
  logic [7:0] cur_byte;

  assign bit_end   = (baud_q == BaudMax);
  assign frame_end = (state_q == StStop) && bit_end && (byte_q == LastByte);
  assign accept    = start && !busy_q;
  // A live start on the final edge chains just like a pending request.
  assign chain     = frame_end && (pending_q || start);
  assign take_snap = accept || chain;

  assign checksum = {1'b0, energy_q} + {1'b0, stress_q} + {1'b0, pleasure_q} + {1'b0, nourish_q};

  always_comb begin
    unique case (byte_q)
      3'd0:    cur_byte = Header;
      3'd1:    cur_byte = {1'b0, energy_q};
      3'd2:    cur_byte = {1'b0, stress_q};
      3'd3:    cur_byte = {1'b0, pleasure_q};
      3'd4:    cur_byte = {1'b0, nourish_q};
      default: cur_byte = checksum;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    energy_d   = energy_q;
    stress_d   = stress_q;
    pleasure_d = pleasure_q;
    nourish_d  = nourish_q;
    pending_d  = pending_q;

    if (take_snap) begin
      energy_d   = dbg_energy;
      stress_d   = dbg_stress;
      pleasure_d = dbg_pleasure;
      nourish_d  = dbg_nourishment;
    end

    if (frame_end) begin
      pending_d = 1'b0;
    end else if (start && busy_q) begin
      pending_d = 1'b1;
    end

    if (state_q == StIdle) begin
      baud_d = '0;
      if (accept) begin
        state_d = StStart;
        byte_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b0;
        busy_d  = 1'b1;
      end
    end else begin
      baud_d = bit_end ? '0 : baud_q + 16'd1;
      if (bit_end) begin
        unique case (state_q)
          StStart: begin
            state_d = StData;
            bit_d   = '0;
            tx_d    = cur_byte[0];
          end
          StData: begin
            if (bit_q == 3'd7) begin
              state_d = StStop;
              tx_d    = 1'b1;
            end else begin
              bit_d = bit_q + 3'd1;
              tx_d  = cur_byte[bit_q + 3'd1];
            end
          end
          default: begin
            if (byte_q != LastByte) begin
              state_d = StStart;
              byte_d  = byte_q + 3'd1;
              tx_d    = 1'b0;
            end else begin
              done_d = 1'b1;
              if (chain) begin
                state_d = StStart;
                byte_d  = '0;
                tx_d    = 1'b0;
              end else begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      energy_q   <= '0;
      stress_q   <= '0;
      pleasure_q <= '0;
      nourish_q  <= '0;
      pending_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      energy_q   <= energy_d;
      stress_q   <= stress_d;
      pleasure_q <= pleasure_d;
      nourish_q  <= nourish_d;
      pending_q  <= pending_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_mimosa_dbg_uart.sv
// Scoreboard bench for mimosa_dbg_uart: stimulus queues expected bytes, a UART monitor decodes
// the tx line and compares each received byte against the queue.
module tb_mimosa_dbg_uart;

  localparam int unsigned Div = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] dbg_e = '0;
  logic [6:0] dbg_s = '0;
  logic [6:0] dbg_p = '0;
  logic [6:0] dbg_n = '0;
  logic       tx;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int last_done = 0;
  int prev_done = 0;
  logic [7:0] exp_q[$];

  mimosa_dbg_uart #(.CLK_DIV(Div)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .dbg_energy      (dbg_e),
    .dbg_stress      (dbg_s),
    .dbg_pleasure    (dbg_p),
    .dbg_nourishment (dbg_n),
    .tx              (tx),
    .busy            (busy),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_frame(input logic [7:0] e, input logic [7:0] s, input logic [7:0] p,
                            input logic [7:0] n, input logic [7:0] cs);
    exp_q.push_back(8'hA5);
    exp_q.push_back(e);
    exp_q.push_back(s);
    exp_q.push_back(p);
    exp_q.push_back(n);
    exp_q.push_back(cs);
  endtask

  task automatic set_inputs(input logic [6:0] e, input logic [6:0] s, input logic [6:0] p,
                            input logic [6:0] n);
    dbg_e = e;
    dbg_s = s;
    dbg_p = p;
    dbg_n = n;
  endtask

  // Returns #1 after the accepting edge, i.e. inside the first start-bit cycle.
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_start_bit(input string name);
    @(negedge clk);
    check({name, "_start_bit"}, {30'd0, tx, busy}, 32'b01);
  endtask

  task automatic wait_idle(input int bound, input string name);
    int i;
    i = 0;
    while (busy && i < bound) begin
      @(negedge clk);
      i++;
    end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic decode_byte();
    logic [9:0] bits;
    logic       stable;
    stable = 1'b1;
    bits   = '0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < int'(Div); j++) begin
        if (k != 0 || j != 0) @(negedge clk);
        if (!rst_n) return;
        if (j == 0) bits[k] = tx;
        else if (tx !== bits[k]) stable = 1'b0;
      end
    end
    check("byte_framing", {29'd0, stable, bits[0], bits[9]}, 32'b101);
    check("byte_available", {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) check("byte_data", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin : uart_monitor
    @(negedge clk);
    if (rst_n && tx == 1'b0) decode_byte();
  end

  initial forever begin : status_monitor
    @(negedge clk);
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (frame_done) begin
        done_cnt++;
        prev_done = last_done;
        last_done = cyc;
      end
    end
  end

  initial begin : stimulus
    int b0;
    int d0;
    int bad;

    // Reset with random inputs
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      set_inputs(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom));
      start = 1'($urandom);
      @(negedge clk);
      check("reset_outputs", {29'd0, tx, busy, frame_done}, 32'b100);
    end
    start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Basic frame
    set_inputs(7'h40, 7'h10, 7'h7F, 7'h00);
    push_frame(8'h40, 8'h10, 8'h7F, 8'h00, 8'hCF);
    b0 = busy_cnt;
    d0 = done_cnt;
    pulse_start();
    check_start_bit("basic");
    wait_idle(300, "basic");
    check("basic_busy_cycles", busy_cnt - b0, 240);
    check("basic_done_pulses", done_cnt - d0, 1);

    // Snapshot isolation
    push_frame(8'h40, 8'h10, 8'h7F, 8'h00, 8'hCF);
    b0 = busy_cnt;
    pulse_start();
    set_inputs(7'h55, 7'h55, 7'h55, 7'h55);
    check_start_bit("snapshot");
    wait_idle(300, "snapshot");
    check("snapshot_busy_cycles", busy_cnt - b0, 240);

    // Pending collapse: three requests during one frame give exactly one chained frame
    set_inputs(7'h11, 7'h22, 7'h33, 7'h44);
    push_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'hAA);
    b0 = busy_cnt;
    d0 = done_cnt;
    pulse_start();
    set_inputs(7'h01, 7'h02, 7'h03, 7'h04);
    push_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
    repeat (20) @(posedge clk);
    pulse_start();
    repeat (60) @(posedge clk);
    pulse_start();
    repeat (60) @(posedge clk);
    pulse_start();
    wait_idle(600, "pending");
    check("pending_busy_cycles", busy_cnt - b0, 480);
    check("pending_done_pulses", done_cnt - d0, 2);
    check("pending_done_spacing", last_done - prev_done, 240);

    // Checksum wrap
    set_inputs(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    push_frame(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'hFC);
    b0 = busy_cnt;
    pulse_start();
    check_start_bit("wrap");
    wait_idle(300, "wrap");
    check("wrap_busy_cycles", busy_cnt - b0, 240);

    // Reset in the middle of byte 2
    set_inputs(7'h05, 7'h06, 7'h07, 7'h08);
    push_frame(8'h05, 8'h06, 8'h07, 8'h08, 8'h1A);
    d0 = done_cnt;
    pulse_start();
    repeat (90) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outputs", {29'd0, tx, busy, frame_done}, 32'b100);
    check("midreset_bytes_left", exp_q.size(), 4);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    check("post_reset_quiet", bad, 0);
    check("post_reset_no_done", done_cnt - d0, 0);

    set_inputs(7'h21, 7'h32, 7'h43, 7'h54);
    push_frame(8'h21, 8'h32, 8'h43, 8'h54, 8'hEA);
    b0 = busy_cnt;
    d0 = done_cnt;
    pulse_start();
    check_start_bit("recover");
    wait_idle(300, "recover");
    check("recover_busy_cycles", busy_cnt - b0, 240);
    check("recover_done_pulses", done_cnt - d0, 1);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mimosa_dbg_uart.md
# mimosa_dbg_uart

Downstream debug consumer for `tt_um_moody_mimosa`. It snapshots the four 7-bit internal state buses (`dbg_energy`, `dbg_stress`, `dbg_pleasure`, `dbg_nourishment`) on request and streams them as a fixed 6-byte UART 8N1 frame. This lets the simulation harness and the FPGA bring-up board log mood evolution over a single serial pin.

## Interface
- `CLK_DIV`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range 2..65535.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  frame request, sampled every cycle; level or pulse.
- `dbg_energy`  in  7  energy state value.
- `dbg_stress`  in  7  stress state value.
- `dbg_pleasure`  in  7  pleasure state value.
- `dbg_nourishment`  in  7  nourishment state value.
- `tx`  out  1  UART line, idle high.
- `busy`  out  1  high while a frame is being transmitted.
- `frame_done`  out  1  one-cycle pulse when a frame's last stop bit completes.

## Operation
- Frame, in order: header 0xA5; `{1'b0,dbg_energy}`; `{1'b0,dbg_stress}`; `{1'b0,dbg_pleasure}`; `{1'b0,dbg_nourishment}`; checksum.
- Checksum: 8-bit sum mod 256 of the four data bytes. The header is excluded.
- Byte format: start bit 0, 8 data bits LSB first, stop bit 1. No gap between bytes, so a frame is exactly 60 bit-times.
- Snapshot: all four inputs are registered on the accepting edge. Later input changes do not affect the frame in flight.
- FSM states: IDLE, START, DATA, STOP.
  - Counters: baud counter 0..CLK_DIV-1, bit index 0..7, byte index 0..5.
  - IDLE -> START when a start is accepted.
  - START -> DATA after 1 bit-time.
  - DATA -> STOP after 8 bit-times.
  - STOP -> START (byte index + 1) after 1 bit-time if byte index < 5.
  - After byte 5, STOP -> IDLE, or -> START of a new frame if pending is set.
- Acceptance: `start`=1 while `busy`=0 begins a frame.
- `start`=1 while `busy`=1 sets a single pending flag. Multiple requests collapse into one.
- Pending is consumed at frame end: the new snapshot is taken on the edge where the final stop bit ends. The pending flag then clears.
- `start` held high continuously yields back-to-back frames with no idle time.
- `start` asserted on the same cycle a frame ends (and pending clear) also chains a new frame.

## Timing
- Reset values: `tx`=1, `busy`=0, `frame_done`=0. Pending, counters, snapshot and FSM are cleared to IDLE.
- Reset mid-frame aborts the frame immediately (asynchronous). `tx` returns high with no partial byte completion.
- Accept at edge N: `busy`=1 and `tx`=0 (start bit) from cycle N+1.
- Each bit holds `tx` for exactly CLK_DIV cycles. Bit k of the frame occupies cycles N+1+k·CLK_DIV .. N+(k+1)·CLK_DIV.
- Last stop bit ends at cycle N+60·CLK_DIV. On the following cycle:
  - `frame_done`=1 for one cycle.
  - `busy`=0 if nothing is pending.
- Chained frame: `busy` stays 1, `frame_done` still pulses once, and the next start bit begins in that same cycle.
- Worst-case request-to-start-bit latency: 60·CLK_DIV cycles, when the request arrives during a frame.

## Test plan
All scenarios use CLK_DIV=4, so a frame is 240 cycles.
- Reset: hold `rst_n`=0 with random inputs -> `tx`=1, `busy`=0, `frame_done`=0 throughout.
- Basic frame: energy=0x40, stress=0x10, pleasure=0x7F, nourishment=0x00, 1-cycle `start`.
  - Decoded bytes: A5 40 10 7F 00 CF.
  - `busy` high for exactly 240 cycles; one `frame_done` pulse.
- Snapshot: change all dbg inputs to 0x55 on the cycle after `start` -> frame still carries 40 10 7F 00 CF.
- Pending collapse: three `start` pulses during the first frame.
  - Exactly two frames, back-to-back: no idle cycle between the final stop bit and the next start bit.
  - Second frame carries values sampled at the first frame's end.
  - Two `frame_done` pulses, 240 cycles apart.
- Wrap: all inputs 0x7F -> checksum 0xFC (0x1FC mod 256). Bit timing is checked on every bit edge, ±0 cycles.
- Reset mid-frame: deassert `rst_n` during byte 2 -> `tx`=1 immediately. After release, no traffic until a new `start`; the next frame is complete and correct.
